// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS datapath. It sequences each instruction class
// and runs the start/done handshake with the external multi-cycle MOD unit.
module multicycle_control #(
    parameter int MOD_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_bit,
    input  logic       mod_done,
    output logic [2:0] alu_ctr,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       mod_start,
    output logic       illegal_op,
    output logic       mod_timeout,
    output logic [3:0] state
);
    localparam logic [3:0] S_INIT = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
                           S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_R_EXEC = 4'd7,
                           S_MOD_WAIT = 4'd8, S_R_WB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
                           S_I_EXEC = 4'd12, S_I_WB = 4'd13;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;

    localparam logic [5:0] FN_MOD = 6'h1A;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOD_TIMEOUT - 1);

    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             funct_ok;
    logic [2:0]       funct_alu;
    logic             is_i_alu;
    logic             mod_expire;

    // R-type funct decode shared by DECODE (legality) and R_EXEC (ALU op).
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b000;
        case (funct)
            6'h20:   funct_alu = 3'b101;
            6'h22:   funct_alu = 3'b110;
            6'h24:   funct_alu = 3'b000;
            6'h25:   funct_alu = 3'b001;
            6'h26:   funct_alu = 3'b010;
            6'h27:   funct_alu = 3'b011;
            6'h2A:   funct_alu = 3'b100;
            FN_MOD:  funct_alu = 3'b111;
            default: funct_ok  = 1'b0;
        endcase
    end

    assign is_i_alu   = (opcode == OP_ADDI) || (opcode == OP_SLTI) || (opcode == OP_ANDI) ||
                        (opcode == OP_ORI)  || (opcode == OP_XORI);
    assign mod_expire = (cnt_reg == CNT_LAST);
    assign state      = state_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = S_INIT;
        case (state_reg)
            S_INIT:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW)        state_next = S_MEM_ADDR;
                else if (opcode == OP_R && funct_ok)           state_next = S_R_EXEC;
                else if (opcode == OP_BEQ || opcode == OP_BNE) state_next = S_BRANCH;
                else if (opcode == OP_J)                       state_next = S_JUMP;
                else if (is_i_alu)                             state_next = S_I_EXEC;
                else                                           state_next = S_FETCH;
            end
            S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_next = S_MEM_WB;
            S_MEM_WB:   state_next = S_FETCH;
            S_MEM_WR:   state_next = S_FETCH;
            S_R_EXEC:   state_next = (funct == FN_MOD) ? S_MOD_WAIT : S_R_WB;
            // A done arriving on the final allowed cycle still wins over the abort.
            S_MOD_WAIT: begin
                if (mod_done)        state_next = S_R_WB;
                else if (mod_expire) state_next = S_FETCH;
                else                 state_next = S_MOD_WAIT;
            end
            S_R_WB:   state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_I_EXEC: state_next = S_I_WB;
            S_I_WB:   state_next = S_FETCH;
            default:  state_next = S_INIT;
        endcase
    end

    assign cnt_next = (state_reg == S_MOD_WAIT && state_next == S_MOD_WAIT) ?
                      cnt_reg + CNT_W'(1) : '0;

    always_comb begin
        alu_ctr     = 3'b000;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        imm_zext    = 1'b0;
        pc_write    = 1'b0;
        pc_source   = 2'b00;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        mod_start   = 1'b0;
        illegal_op  = 1'b0;
        mod_timeout = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctr   = 3'b101;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                alu_ctr    = 3'b101;
                illegal_op = (state_next == S_FETCH);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctr   = 3'b101;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctr   = funct_alu;
                mod_start = (funct == FN_MOD);
            end
            S_MOD_WAIT: begin
                alu_src_a   = 1'b1;
                alu_ctr     = 3'b111;
                mod_timeout = mod_expire && !mod_done;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctr   = 3'b110;
                pc_source = 2'b01;
                pc_write  = ((opcode == OP_BEQ) && zero_bit) || ((opcode == OP_BNE) && !zero_bit);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                imm_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
                case (opcode)
                    OP_ADDI: alu_ctr = 3'b101;
                    OP_SLTI: alu_ctr = 3'b100;
                    OP_ANDI: alu_ctr = 3'b000;
                    OP_ORI:  alu_ctr = 3'b001;
                    OP_XORI: alu_ctr = 3'b010;
                    default: alu_ctr = 3'b000;
                endcase
            end
            S_I_WB: reg_write = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: each instruction is expanded into its expected per-cycle control
// vectors by instruction class, then played against the FSM one cycle at a time.
module tb_multicycle_control;
    typedef struct packed {
        logic [3:0] st;
        logic [2:0] ctr;
        logic       sa;
        logic [1:0] sb;
        logic       zx, pw;
        logic [1:0] ps;
        logic       iord, mr, mw, irw, rw, rd, m2r, ms, ill, mto;
    } ov_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00, funct = 6'h00;
    logic       zero_bit = 1'b0, mod_done = 1'b0;
    logic [2:0] alu_ctr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext, pc_write;
    logic [1:0] pc_source;
    logic       iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
    logic       mod_start, illegal_op, mod_timeout;
    logic [3:0] state;
    ov_t        obs;

    int n_vec = 0;
    int n_bad = 0;

    ov_t   exp_q[$];
    string tag_q[$];
    bit    done_q[$];

    always #5 clk = ~clk;

    multicycle_control #(.MOD_TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero_bit(zero_bit),
        .mod_done(mod_done), .alu_ctr(alu_ctr), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_zext(imm_zext), .pc_write(pc_write), .pc_source(pc_source), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mod_start(mod_start),
        .illegal_op(illegal_op), .mod_timeout(mod_timeout), .state(state)
    );

    assign obs = {state, alu_ctr, alu_src_a, alu_src_b, imm_zext, pc_write, pc_source, iord,
                  mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, mod_start,
                  illegal_op, mod_timeout};

    task automatic check_vec(input string tag, input ov_t got, input ov_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                     tag, got, exp, got.st, exp.st);
        end
    endtask

    function automatic ov_t ph(input logic [3:0] st);
        ov_t v = '0;
        v.st = st;
        return v;
    endfunction

    task automatic push(input string tag, input ov_t v, input bit done);
        exp_q.push_back(v);
        tag_q.push_back(tag);
        done_q.push_back(done);
    endtask

    function automatic bit r_alu(input logic [5:0] fn, output logic [2:0] op);
        op = 3'b000;
        case (fn)
            6'h20: op = 3'b101;
            6'h22: op = 3'b110;
            6'h24: op = 3'b000;
            6'h25: op = 3'b001;
            6'h26: op = 3'b010;
            6'h27: op = 3'b011;
            6'h2A: op = 3'b100;
            6'h1A: op = 3'b111;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // d = cycle (1-based) of MOD_WAIT at which done rises; 0 or > 64 means never.
    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input bit zr, input int d);
        ov_t v;
        logic [2:0] ra;
        bit r_ok;
        int nw;
        r_ok = r_alu(fn, ra);
        v = ph(4'd1); v.mr = 1; v.irw = 1; v.pw = 1; v.sb = 2'b01; v.ctr = 3'b101;
        push("fetch", v, 1'($urandom));
        v = ph(4'd2); v.sb = 2'b11; v.ctr = 3'b101;
        case (op)
            6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: v.ill = 0;
            6'h00: v.ill = !r_ok;
            default: v.ill = 1;
        endcase
        push("decode", v, 1'($urandom));
        if (v.ill) return;
        case (op)
            6'h23, 6'h2B: begin
                v = ph(4'd3); v.sa = 1; v.sb = 2'b10; v.ctr = 3'b101;
                push("mem_addr", v, 1'($urandom));
                if (op == 6'h23) begin
                    v = ph(4'd4); v.mr = 1; v.iord = 1; push("mem_rd", v, 1'($urandom));
                    v = ph(4'd5); v.rw = 1; v.m2r = 1; push("mem_wb", v, 1'($urandom));
                end else begin
                    v = ph(4'd6); v.mw = 1; v.iord = 1; push("mem_wr", v, 1'($urandom));
                end
            end
            6'h04, 6'h05: begin
                v = ph(4'd10); v.sa = 1; v.ctr = 3'b110; v.ps = 2'b01;
                v.pw = (op == 6'h04) ? zr : !zr;
                push("branch", v, 1'($urandom));
            end
            6'h02: begin
                v = ph(4'd11); v.pw = 1; v.ps = 2'b10; push("jump", v, 1'($urandom));
            end
            6'h00: begin
                v = ph(4'd7); v.sa = 1; v.ctr = ra; v.ms = (fn == 6'h1A);
                push("r_exec", v, 1'($urandom));
                if (fn == 6'h1A) begin
                    nw = (d >= 1 && d <= 64) ? d : 64;
                    for (int k = 0; k < nw; k++) begin
                        v = ph(4'd8); v.sa = 1; v.ctr = 3'b111;
                        v.mto = (k == 63) && (nw != d);
                        push("mod_wait", v, (k == d - 1));
                    end
                end
                if (fn != 6'h1A || (d >= 1 && d <= 64)) begin
                    v = ph(4'd9); v.rw = 1; v.rd = 1; push("r_wb", v, 1'($urandom));
                end
            end
            default: begin
                v = ph(4'd12); v.sa = 1; v.sb = 2'b10;
                v.zx = (op == 6'h0C || op == 6'h0D || op == 6'h0E);
                case (op)
                    6'h08:   v.ctr = 3'b101;
                    6'h0A:   v.ctr = 3'b100;
                    6'h0C:   v.ctr = 3'b000;
                    6'h0D:   v.ctr = 3'b001;
                    default: v.ctr = 3'b010;
                endcase
                push("i_exec", v, 1'($urandom));
                v = ph(4'd13); v.rw = 1; push("i_wb", v, 1'($urandom));
            end
        endcase
    endtask

    // Inputs change only on the first (FETCH) cycle, so DECODE onward sees them stable.
    task automatic play(input logic [5:0] op, input logic [5:0] fn, input bit zr);
        bit first = 1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (first) begin
                opcode = op; funct = fn; zero_bit = zr; first = 0;
            end
            mod_done = done_q.pop_front();
            #1;
            check_vec(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input bit zr, input int d);
        gen_instr(op, fn, zr, d);
        play(op, fn, zr);
    endtask

    logic [5:0] ops[12] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                            6'h0E, 6'h23, 6'h2B, 6'h00};
    logic [5:0] fns[9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h1A, 6'h1A};

    initial begin
        logic [5:0] op, fn;
        ov_t v;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_vec("reset_init", obs, ph(4'd0));

        run(6'h23, 6'h00, 1'b0, 0);
        run(6'h2B, 6'h00, 1'b0, 0);
        run(6'h04, 6'h00, 1'b1, 0);
        run(6'h04, 6'h00, 1'b0, 0);
        run(6'h05, 6'h00, 1'b1, 0);
        run(6'h05, 6'h00, 1'b0, 0);
        run(6'h00, 6'h1A, 1'b0, 5);
        run(6'h00, 6'h1A, 1'b0, 0);
        run(6'h00, 6'h1A, 1'b0, 64);
        run(6'h3F, 6'h20, 1'b0, 0);
        run(6'h00, 6'h00, 1'b0, 0);
        run(6'h02, 6'h00, 1'b0, 0);

        // Reset during MEM_RD of a load: next cycle must be INIT with no register write.
        gen_instr(6'h23, 6'h00, 1'b0, 0);
        void'(exp_q.pop_back()); void'(tag_q.pop_back()); void'(done_q.pop_back());
        play(6'h23, 6'h00, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_vec("reset_mid_mem_rd", obs, ph(4'd0));
        reset = 1'b0;

        for (int i = 0; i < 200; i++) begin
            op = ops[$urandom_range(0, 11)];
            fn = fns[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
            run(op, fn, 1'($urandom), $urandom_range(0, 70));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
